// File: rtl/mem_sram_ctrl_pkg.sv
// rtl/mem_sram_ctrl_pkg.sv - shared widths, FSM encoding and address helpers for mem_sram_ctrl
package mem_sram_ctrl_pkg;

    localparam int ADDRESS_LEN       = 32;
    localparam int REGISTER_FILE_LEN = 32;
    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_IDX_W        = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Word index into SRAM; wraps modulo 2^17 when the offset is too large.
    function automatic logic [SRAM_IDX_W-1:0] sram_index(
        input logic [ADDRESS_LEN-1:0] addr,
        input logic [ADDRESS_LEN-1:0] base
    );
        return SRAM_IDX_W'((addr - base) >> 2);
    endfunction

    function automatic int wait_cnt_w(input int wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_sram_ctrl_sram_wait_counter.sv
// rtl/mem_sram_ctrl_sram_wait_counter.sv - loadable down-counter with terminal-count flag
module sram_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage 32-bit load/store over 16-bit SRAM; MEM_RANGE_CHECK_EN adds range check
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT = 5,
    parameter int DATA_BASE = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_r_en,
    input  logic                         mem_w_en,
    input  logic [ADDRESS_LEN-1:0]       address,
    input  logic [REGISTER_FILE_LEN-1:0] write_data,
    output logic [REGISTER_FILE_LEN-1:0] read_data,
    output logic                         ready,
    output logic                         addr_err,
    output logic [SRAM_ADDR_W-1:0]       sram_addr,
    output logic [SRAM_DATA_W-1:0]       sram_dq_out,
    input  logic [SRAM_DATA_W-1:0]       sram_dq_in,
    output logic                         sram_dq_oe,
    output logic                         sram_we_n
);

    localparam int                     CNT_W     = wait_cnt_w(SRAM_WAIT);
    localparam logic [CNT_W-1:0]       WAIT_LAST = CNT_W'(SRAM_WAIT - 1);
    localparam logic [ADDRESS_LEN-1:0] BASE      = ADDRESS_LEN'(DATA_BASE);

    state_e                         state_q, state_d;
    logic [SRAM_IDX_W-1:0]          idx_q, idx_d;
    logic [REGISTER_FILE_LEN-1:0]   wdata_q, wdata_d;
    logic                           is_write_q, is_write_d;
    logic [REGISTER_FILE_LEN-1:0]   rdata_q, rdata_d;
    logic                           cnt_load, cnt_en, cnt_tc;
    logic                           req;

    assign req = mem_r_en | mem_w_en;

`ifdef MEM_RANGE_CHECK_EN
    logic [ADDRESS_LEN-1:0] addr_off;
    logic                   out_of_range;
    logic                   addr_err_q, addr_err_d;

    assign addr_off     = address - BASE;
    assign out_of_range = (address < BASE) || ((addr_off >> (SRAM_IDX_W + 2)) != '0);
    assign addr_err     = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    sram_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (WAIT_LAST),
        .en         (cnt_en),
        .tc         (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        rdata_d     = rdata_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        ready       = 1'b1;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
`ifdef MEM_RANGE_CHECK_EN
        addr_err_d  = addr_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ready      = 1'b0;
                    idx_d      = sram_index(address, BASE);
                    wdata_d    = write_data;
                    is_write_d = mem_w_en;
                    cnt_load   = 1'b1;
                    state_d    = ST_LOW;
`ifdef MEM_RANGE_CHECK_EN
                    // Out-of-range requests never touch the bus.
                    if (out_of_range) begin
                        cnt_load   = 1'b0;
                        state_d    = ST_DONE;
                        addr_err_d = 1'b1;
                        if (!mem_w_en) begin
                            rdata_d = '0;
                        end
                    end
`endif
                end
            end
            ST_LOW: begin
                ready     = 1'b0;
                cnt_en    = 1'b1;
                sram_addr = {idx_q, 1'b0};
                if (is_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = wdata_q[15:0];
                end
                if (cnt_tc) begin
                    if (!is_write_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    cnt_load = 1'b1;
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                ready     = 1'b0;
                cnt_en    = 1'b1;
                sram_addr = {idx_q, 1'b1};
                if (is_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = wdata_q[31:16];
                end
                if (cnt_tc) begin
                    if (!is_write_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_RANGE_CHECK_EN
            addr_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
`ifdef MEM_RANGE_CHECK_EN
            addr_err_q <= addr_err_d;
`endif
        end
    end

    assign read_data = rdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - self-checking bench for mem_sram_ctrl with transaction model and SRAM model
module tb_mem_sram_ctrl;

    localparam int W    = 5;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    mem_sram_ctrl #(
        .SRAM_WAIT (W),
        .DATA_BASE (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .addr_err    (addr_err),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ready;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        oe;
        logic        we_n;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    function automatic exp_t mk(input logic rdy, input logic [17:0] a, input logic [15:0] dq,
                                input logic oe, input logic we_n, input logic crd, input logic [31:0] rd);
        exp_t e;
        e.ready = rdy; e.addr = a; e.dq = dq; e.oe = oe; e.we_n = we_n; e.chk_rd = crd; e.rd = rd;
        return e;
    endfunction

    exp_t        expq[$];
    logic [31:0] model_rd = '0;
    logic        model_err = 1'b0;
    bit          cmp_en = 1'b0;
    int          low_run = 0, high_run = 0, last_low = 0, last_gap = 0;

    // Behavioural SRAM: a write commits only after W consecutive strobed cycles at one address.
    logic [15:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:63];
    int          wcnt = 0;
    logic [17:0] waddr = '0;

    assign sram_dq_in = sram_mem[sram_addr[7:0]];

    always @(negedge clk) begin
        if (!sram_we_n) begin
            if (wcnt != 0 && sram_addr == waddr) wcnt++;
            else wcnt = 1;
            waddr = sram_addr;
            if (wcnt == W) sram_mem[sram_addr[7:0]] = sram_dq_out;
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin : cmp_blk
        exp_t e;
        if (cmp_en && rst) begin
            if (expq.size() > 0) e = expq.pop_front();
            else e = mk(1'b1, '0, '0, 1'b0, 1'b1, 1'b1, model_rd);
            chk("ready", {31'd0, ready}, {31'd0, e.ready});
            chk("sram_addr", {14'd0, sram_addr}, {14'd0, e.addr});
            chk("sram_dq_out", {16'd0, sram_dq_out}, {16'd0, e.dq});
            chk("sram_dq_oe", {31'd0, sram_dq_oe}, {31'd0, e.oe});
            chk("sram_we_n", {31'd0, sram_we_n}, {31'd0, e.we_n});
            chk("addr_err", {31'd0, addr_err}, {31'd0, model_err});
            if (e.chk_rd) chk("read_data", read_data, e.rd);
            if (!ready) begin
                if (low_run == 0) last_gap = high_run;
                low_run++;
            end else begin
                if (low_run != 0) begin
                    last_low = low_run;
                    high_run = 0;
                end
                low_run = 0;
                high_run++;
            end
        end
    end

    logic [17:0] snap_addr [0:31];
    logic [15:0] snap_dq   [0:31];
    logic        snap_we   [0:31];
    logic [31:0] snap_rd   [0:31];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
        end
    endtask

    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input int abort_at);
        logic [16:0] idx;
        logic [31:0] new_rd;
        bit          oor;
        oor = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        oor = (a < 32'(BASE)) || (((a - 32'(BASE)) >> 2) >= 32'h20000);
`endif
        idx    = 17'((a - 32'(BASE)) >> 2);
        new_rd = w ? model_rd : (oor ? 32'd0 : ref_mem[idx[5:0]]);
        @(posedge clk); #1;
        mem_w_en = w; mem_r_en = r; address = a; write_data = d;
        expq.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, model_rd));
        if (oor) begin
            expq.push_back(mk(1'b1, '0, '0, 1'b0, 1'b1, 1'b1, new_rd));
            @(posedge clk); #1;
            snap_rd[1] = read_data;
            model_rd  = new_rd;
            model_err = 1'b1;
            return;
        end
        for (int c = 0; c < W; c++)
            expq.push_back(mk(1'b0, {idx, 1'b0}, w ? d[15:0] : 16'd0, w, !w, w, model_rd));
        for (int c = 0; c < W; c++)
            expq.push_back(mk(1'b0, {idx, 1'b1}, w ? d[31:16] : 16'd0, w, !w, w, model_rd));
        expq.push_back(mk(1'b1, '0, '0, 1'b0, 1'b1, 1'b1, new_rd));
        for (int c = 1; c <= 2 * W + 1; c++) begin
            @(posedge clk); #1;
            if (c == abort_at) begin
                rst = 1'b0; mem_w_en = 1'b0; mem_r_en = 1'b0;
                expq.delete();
                #1;
                chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
                chk("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
                chk("abort_addr", {14'd0, sram_addr}, 32'd0);
                chk("abort_rd", read_data, 32'd0);
                chk("abort_ready", {31'd0, ready}, 32'd1);
                model_rd = '0;
                #1 rst = 1'b1;
                return;
            end
            if (c == 1) begin
                address = $urandom;
                write_data = $urandom;
            end
            snap_addr[c] = sram_addr; snap_dq[c] = sram_dq_out;
            snap_we[c] = sram_we_n;   snap_rd[c] = read_data;
        end
        model_rd = new_rd;
        if (w) ref_mem[idx[5:0]] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_dq", {16'd0, sram_dq_out}, 32'd0);
        chk("rst_rd", read_data, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        rst = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 0);
        chk("st_lo_addr", {14'd0, snap_addr[1]}, 32'd2);
        chk("st_lo_dq", {16'd0, snap_dq[1]}, 32'h0000BEEF);
        chk("st_lo_we", {31'd0, snap_we[1]}, 32'd0);
        chk("st_lo_last_addr", {14'd0, snap_addr[W]}, 32'd2);
        chk("st_hi_addr", {14'd0, snap_addr[W + 1]}, 32'd3);
        chk("st_hi_dq", {16'd0, snap_dq[W + 1]}, 32'h0000DEAD);
        chk("st_hi_we", {31'd0, snap_we[2 * W]}, 32'd0);
        chk("st_done_we", {31'd0, snap_we[2 * W + 1]}, 32'd1);
        idle(1);
        chk("freeze_len", last_low, 32'd11);

        do_access(1'b0, 1'b1, 32'd1028, 32'd0, 0);
        chk("load_1028", snap_rd[2 * W + 1], 32'hDEADBEEF);
        idle(2);

        do_access(1'b0, 1'b1, 32'd1028, 32'd0, 0);
        do_access(1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 0);
        chk("b2b_gap", last_gap, 32'd1);
        idle(1);
        do_access(1'b0, 1'b1, 32'd1040, 32'd0, 0);
        chk("load_1040", snap_rd[2 * W + 1], 32'h0BADF00D);

        idle(1);
        do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 0);
        chk("both_rd_kept", snap_rd[2 * W + 1], 32'h0BADF00D);
        idle(1);
        do_access(1'b0, 1'b1, 32'd1024, 32'd0, 0);
        chk("load_1024", snap_rd[2 * W + 1], 32'h12345678);

        idle(1);
        do_access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, W + 3);
        ref_mem[1][15:0] = 16'hF00D;
        idle(1);
        do_access(1'b0, 1'b1, 32'd1028, 32'd0, 0);
        chk("abort_load", snap_rd[2 * W + 1], 32'hDEADF00D);

`ifdef MEM_RANGE_CHECK_EN
        idle(1);
        do_access(1'b0, 1'b1, 32'd512, 32'd0, 0);
        chk("oor_rd", snap_rd[1], 32'd0);
        chk("oor_err", {31'd0, addr_err}, 32'd1);
        idle(3);
        chk("oor_err_sticky", {31'd0, addr_err}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        #1;
        chk("oor_err_rst", {31'd0, addr_err}, 32'd0);
        model_err = 1'b0;
        model_rd  = '0;
        rst = 1'b1;
`endif

        idle(2);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
